// File: rtl/si_upscaler.sv
// si_upscaler: registered signed-integer width upscaler.
// Sign-extends an N_IN-bit two's-complement sample to N_OUT bits, then applies
// a constant arithmetic left shift of SHIFT bits. One cycle of latency.
//
// Build option: define SI_UPSCALER_SAT_EN to saturate an overflowing value to
// Rmin/Rmax and flag it on ovf. Without it, an overflowing value wraps (only
// the low N_OUT bits are kept), no compare logic is built and ovf is tied 0.
//
// Handshake: valid-only, no ready. A sample is accepted at every rising clk
// edge where in_valid=1 and rst=0; out_valid is high for exactly the one cycle
// following each accepted sample. With in_valid=0, out and ovf hold.
module si_upscaler #(
    parameter int N_IN  = 8,
    parameter int N_OUT = 16,
    parameter int SHIFT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [N_IN-1:0]  in,
    output logic             out_valid,
    output logic [N_OUT-1:0] out,
    output logic             ovf
);
    // Full-precision width, widened so there is always at least one guard bit
    // above the output sign bit.
    localparam int WFULL = N_IN + SHIFT + 1;
    localparam int WV    = (WFULL > N_OUT + 1) ? WFULL : N_OUT + 1;

    if (N_IN < 2) begin : g_bad_nin
        $error("si_upscaler: N_IN must be at least 2");
    end
    if (N_OUT < N_IN) begin : g_bad_nout
        $error("si_upscaler: N_OUT must be >= N_IN");
    end
    if (SHIFT < 0 || SHIFT > N_OUT - 1) begin : g_bad_shift
        $error("si_upscaler: SHIFT must be in 0..N_OUT-1");
    end

    logic signed [WV-1:0] v_ext;
    logic signed [WV-1:0] v_full;
    logic [N_OUT-1:0]     out_d, out_q;
    logic                 out_valid_d, out_valid_q;

    // Full-precision value: sign extension followed by the constant shift.
    always_comb begin
        v_ext  = {{(WV-N_IN){in[N_IN-1]}}, in};
        v_full = v_ext <<< SHIFT;
    end

`ifdef SI_UPSCALER_SAT_EN
    logic ovf_d, ovf_q;
    logic pos_ovf, neg_ovf;

    // Value fits only when every bit from the output sign bit upward matches.
    always_comb begin
        pos_ovf = ~v_full[WV-1] & (|v_full[WV-2:N_OUT-1]);
        neg_ovf =  v_full[WV-1] & ~(&v_full[WV-2:N_OUT-1]);
    end

    // Next output: saturate on overflow, hold when no sample is presented.
    always_comb begin
        out_valid_d = in_valid;
        out_d       = out_q;
        ovf_d       = ovf_q;
        if (in_valid) begin
            if (pos_ovf) begin
                out_d = {1'b0, {(N_OUT-1){1'b1}}};
            end else if (neg_ovf) begin
                out_d = {1'b1, {(N_OUT-1){1'b0}}};
            end else begin
                out_d = v_full[N_OUT-1:0];
            end
            ovf_d = pos_ovf | neg_ovf;
        end
    end

    // Overflow flag register, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    // Bits above the output width are discarded when wrapping.
    logic unused_hi;
    assign unused_hi = ^v_full[WV-1:N_OUT];

    // Next output: keep the low N_OUT bits, hold when no sample is presented.
    always_comb begin
        out_valid_d = in_valid;
        out_d       = out_q;
        if (in_valid) begin
            out_d = v_full[N_OUT-1:0];
        end
    end

    assign ovf = 1'b0;
`endif

    // Output and valid registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_si_upscaler.sv
// Bench for si_upscaler: three instances (defaults; 8->10 with SHIFT=4;
// 4->4) driven in lockstep, checked against an arithmetic reference model.
// Both build options (SI_UPSCALER_SAT_EN defined or not) are handled.
module tb_si_upscaler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in0 = '0;
  logic [7:0]  in1 = '0;
  logic [3:0]  in2 = '0;
  logic        ov0, ov1, ov2;
  logic [15:0] out0;
  logic [9:0]  out1;
  logic [3:0]  out2;
  logic        f0, f1, f2;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] exp_q[$];
  logic [31:0] last_o[3];
  logic        last_f[3];

  // clock / reset
  always #5 clk = ~clk;

  si_upscaler #(.N_IN(8), .N_OUT(16), .SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in0),
    .out_valid(ov0), .out(out0), .ovf(f0));
  si_upscaler #(.N_IN(8), .N_OUT(10), .SHIFT(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in1),
    .out_valid(ov1), .out(out1), .ovf(f1));
  si_upscaler #(.N_IN(4), .N_OUT(4), .SHIFT(0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in2),
    .out_valid(ov2), .out(out2), .ovf(f2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: integer value in*2^sh, then fit / saturate / wrap.
  function automatic void ref_model(input int nin, input int nout, input int sh,
                                    input logic [31:0] raw,
                                    output logic [31:0] o, output logic f);
    longint s, v, rmax, rmin, mask;
    s = longint'(raw);
    if (raw[nin-1]) s = s - (longint'(1) << nin);
    v    = s * (longint'(1) << sh);
    rmax = (longint'(1) << (nout-1)) - 1;
    rmin = -(longint'(1) << (nout-1));
    mask = (longint'(1) << nout) - 1;
    f = 1'b0;
    o = 32'(v & mask);
    if (v > rmax || v < rmin) begin
`ifdef SI_UPSCALER_SAT_EN
      o = 32'(((v > rmax) ? rmax : rmin) & mask);
      f = 1'b1;
`endif
    end
  endfunction

  // driver: present one cycle of inputs, then check all three instances
  task automatic step(input logic v, input logic [7:0] a0, input logic [7:0] a1, input logic [3:0] a2);
    logic [31:0] o;
    logic        f;
    @(negedge clk);
    in_valid = v; in0 = a0; in1 = a1; in2 = a2;
    if (v) begin
      ref_model(8, 16, 0, {24'd0, a0}, o, f); last_o[0] = o; last_f[0] = f;
      ref_model(8, 10, 4, {24'd0, a1}, o, f); last_o[1] = o; last_f[1] = f;
      ref_model(4, 4, 0, {28'd0, a2}, o, f);  last_o[2] = o; last_f[2] = f;
    end
    for (int k = 0; k < 3; k++) exp_q.push_back(last_o[k]);
    @(posedge clk);
    #1;
    check("out0", {16'd0, out0}, exp_q.pop_front());
    check("out1", {22'd0, out1}, exp_q.pop_front());
    check("out2", {28'd0, out2}, exp_q.pop_front());
    check("valid0", {31'd0, ov0}, {31'd0, v});
    check("valid1", {31'd0, ov1}, {31'd0, v});
    check("valid2", {31'd0, ov2}, {31'd0, v});
    check("ovf0", {31'd0, f0}, {31'd0, last_f[0]});
    check("ovf1", {31'd0, f1}, {31'd0, last_f[1]});
    check("ovf2", {31'd0, f2}, {31'd0, last_f[2]});
  endtask

  typedef struct {
    logic [7:0]  in;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [9:0] e40, e80;
    logic       g40, g80;

    for (int k = 0; k < 3; k++) begin last_o[k] = '0; last_f[k] = 1'b0; end

    vecs[0]  = '{8'h00, 16'h0000}; vecs[1]  = '{8'h01, 16'h0001};
    vecs[2]  = '{8'h02, 16'h0002}; vecs[3]  = '{8'h03, 16'h0003};
    vecs[4]  = '{8'h07, 16'h0007}; vecs[5]  = '{8'hFF, 16'hFFFF};
    vecs[6]  = '{8'hFE, 16'hFFFE}; vecs[7]  = '{8'hFD, 16'hFFFD};
    vecs[8]  = '{8'hF9, 16'hFFF9}; vecs[9]  = '{8'hF8, 16'hFFF8};
    vecs[10] = '{8'h7F, 16'h007F}; vecs[11] = '{8'h80, 16'hFF80};

    // reset state
    #1;
    check("rst_out0", {16'd0, out0}, 32'd0);
    check("rst_valid0", {31'd0, ov0}, 32'd0);
    check("rst_ovf1", {31'd0, f1}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // table vectors on the default instance
    for (int i = 0; i < 12; i++) begin
      step(1'b1, vecs[i].in, 8'h00, 4'h0);
      check("tbl_out0", {16'd0, out0}, {16'd0, vecs[i].exp});
      check("tbl_ovf0", {31'd0, f0}, 32'd0);
    end

    // hold: idle cycles with changing input
    step(1'b1, 8'h7F, 8'h01, 4'h7);
    step(1'b0, 8'h12, 8'h34, 4'h5);
    check("hold_out0", {16'd0, out0}, 32'h007F);
    check("hold_valid0", {31'd0, ov0}, 32'd0);
    step(1'b0, 8'h99, 8'hAA, 4'hB);
    check("hold2_out0", {16'd0, out0}, 32'h007F);

    // shifted instance corner cases
`ifdef SI_UPSCALER_SAT_EN
    e40 = 10'h1FF; g40 = 1'b1; e80 = 10'h200; g80 = 1'b1;
`else
    e40 = 10'h000; g40 = 1'b0; e80 = 10'h000; g80 = 1'b0;
`endif
    step(1'b1, 8'h00, 8'h05, 4'h9);
    check("sh_05_out1", {22'd0, out1}, 32'h050);
    check("sh_05_ovf1", {31'd0, f1}, 32'd0);
    check("eq_9_out2", {28'd0, out2}, 32'h9);
    step(1'b1, 8'h00, 8'h40, 4'h0);
    check("sh_40_out1", {22'd0, out1}, {22'd0, e40});
    check("sh_40_ovf1", {31'd0, f1}, {31'd0, g40});
    step(1'b0, 8'h00, 8'h00, 4'h0);
    check("sh_hold_ovf1", {31'd0, f1}, {31'd0, g40});
    step(1'b1, 8'h00, 8'h80, 4'h0);
    check("sh_80_out1", {22'd0, out1}, {22'd0, e80});
    check("sh_80_ovf1", {31'd0, f1}, {31'd0, g80});

    // reset mid-stream: sample presented in that cycle is discarded
    step(1'b1, 8'h11, 8'h02, 4'h3);
    @(negedge clk);
    in_valid = 1'b1; in0 = 8'h55; in1 = 8'h40; in2 = 4'h8;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out0", {16'd0, out0}, 32'd0);
    check("mid_rst_valid0", {31'd0, ov0}, 32'd0);
    check("mid_rst_out1", {22'd0, out1}, 32'd0);
    @(posedge clk);
    #1;
    check("mid_rst_edge_valid0", {31'd0, ov0}, 32'd0);
    check("mid_rst_edge_out0", {16'd0, out0}, 32'd0);
    for (int k = 0; k < 3; k++) begin last_o[k] = '0; last_f[k] = 1'b0; end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    step(1'b0, 8'h23, 8'h45, 4'h6);

    // randomized stimulus against the reference model
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/si_upscaler.md
# si_upscaler

Registered signed-integer width upscaler. Converts an N_IN-bit two's-complement sample to N_OUT bits by sign extension, with an optional arithmetic left shift for fixed-point rescaling. It sits between narrow integer producers, such as quantised inputs and weights, and the wider accumulator datapath of the neural-network core. Output is registered, with one cycle of latency and a valid qualifier.

## Interface
- N_IN, default 8: input width in bits, signed. Minimum 2.
- N_OUT, default 16: output width in bits, signed. N_OUT >= N_IN is required; otherwise elaboration stops with `$error`.
- SHIFT, default 0: constant arithmetic left shift applied after extension, in the range 0..N_OUT-1.

Ports:
- clk, input, 1: the single clock; all state updates on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: qualifies `in` in the current cycle.
- in, input, N_IN: signed two's-complement sample.
- out_valid, output, 1: registered; high for exactly one cycle per accepted sample.
- out, output, N_OUT: registered signed result.
- ovf, output, 1: registered; high alongside `out_valid` when the shifted value did not fit in N_OUT bits.

## Operation
- Full-precision value is v = sign_extend(in) * 2^SHIFT, computed internally at N_IN+SHIFT+1 bits.
- Output range is Rmin = -2^(N_OUT-1) to Rmax = 2^(N_OUT-1)-1.
- Fit case (v within Rmin..Rmax): out = v, exactly, and ovf = 0.
- When SHIFT = 0, the fit case always applies: out is pure sign extension and ovf is always 0.
- Overflow case (v outside the range) is handled as defined in Configuration.
- in_valid = 1 at an edge: out, ovf and out_valid are updated together.
- in_valid = 0 at an edge: out and ovf hold their previous values, and out_valid goes to 0.
- No backpressure; a new sample can be accepted every cycle.
- Boundary values:
  - in = 0 gives all-zero out.
  - in = -2^(N_IN-1), the most negative input, extends correctly with no special case.
  - in = 2^(N_IN-1)-1, the most positive input, extends with zero upper bits.

## Timing
- Latency is 1 clock: a sample accepted at edge k appears on out/out_valid/ovf immediately after edge k.
- Throughput is 1 sample per clock.
- Reset values while rst is high: out = 0, out_valid = 0, ovf = 0. Outputs clear asynchronously on assertion.
- rst asserted mid-stream discards any sample presented in that cycle; no output pulse follows.
- First acceptance after rst deasserts is at the first rising edge with rst = 0 and in_valid = 1.
- No combinational path from in to out.

## Configuration
- Macro: SI_UPSCALER_SAT_EN.
- Defined: an overflowing v saturates. out = Rmax if v > Rmax, out = Rmin if v < Rmin, and ovf = 1 for that sample.
- Undefined: an overflowing v wraps, keeping only the low N_OUT bits of v. The saturation and compare logic is not built, and ovf is tied to 0.
- Fit-case behaviour is identical in both builds.

## Test plan
- Default parameters (N_IN=8, N_OUT=16, SHIFT=0): in = 0, 1, 2, 3, 7 with in_valid -> out = 0x0000, 0x0001, 0x0002, 0x0003, 0x0007 one cycle later, out_valid pulses, ovf = 0.
- Defaults: in = 0xFF, 0xFE, 0xFD, 0xF9, 0xF8 (-1, -2, -3, -7, -8) -> out = 0xFFFF, 0xFFFE, 0xFFFD, 0xFFF9, 0xFFF8.
- Defaults: in = 0x7F -> 0x007F; in = 0x80 -> 0xFF80.
- in_valid toggling, with in_valid = 0 while in changes:
  - out holds its last value and out_valid = 0 in each idle cycle.
  - rst pulsed mid-stream -> out = 0 and out_valid = 0 immediately.
- N_IN=8, N_OUT=10, SHIFT=4:
  - in = 0x05 -> out = 0x050, ovf = 0.
  - in = 0x40 (1024 unclipped), SAT_EN defined -> out = 0x1FF, ovf = 1.
  - in = 0x40, SAT_EN undefined -> out = 0x000, ovf = 0.
  - in = 0x80 (-2048 unclipped), SAT_EN defined -> out = 0x200, ovf = 1.
- N_IN=4, N_OUT=4, SHIFT=0 (equal widths): in = 0x9 -> out = 0x9, ovf = 0.
